// File: rtl/add_pkg.sv
// Shared widths and state type for the adder sum accumulator slice.
package add_pkg;

  localparam int unsigned DEF_SUM_W = 5;
  localparam int unsigned DEF_ACC_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } accum_state_e;

endpackage

// File: rtl/sat_add.sv
// Saturating adder: ACC_W-bit accumulator plus a zero-extended SUM_W-bit operand.
module sat_add #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned SUM_W = 5
) (
  input  logic [ACC_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  always_comb begin
    full = {1'b0, a} + (ACC_W + 1)'(b);
    ovf  = full[ACC_W];
    sum  = ovf ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/add_sum_accum.sv
// Accumulates NUM_SAMPLES adder sums (fewer on flush) into a saturating total and
// holds total/count/saturation until the sink accepts them.
module add_sum_accum
  import add_pkg::*;
#(
  parameter int unsigned SUM_W       = DEF_SUM_W,
  parameter int unsigned ACC_W       = DEF_ACC_W,
  parameter int unsigned NUM_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] in_sum,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [7:0]       out_count,
  output logic             out_sat
);

  localparam logic [7:0] LAST = 8'(NUM_SAMPLES);

  accum_state_e     state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] add_sum;
  logic [ACC_W-1:0] new_acc;
  logic [7:0]       cnt;
  logic [7:0]       new_cnt;
  logic             sat;
  logic             new_sat;
  logic             add_ovf;
  logic             accept;
  logic             close;
  logic             rdy;

  sat_add #(
    .ACC_W(ACC_W),
    .SUM_W(SUM_W)
  ) u_sat_add (
    .a  (acc),
    .b  (in_sum),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // rdy is a registered copy of (state != HOLD), held low through reset and
  // for the first cycle after release.
  assign in_ready = rdy;

  always_comb begin
    accept  = in_valid & rdy;
    new_acc = accept ? add_sum : acc;
    new_sat = sat | (accept & add_ovf);
    new_cnt = cnt + {7'b0, accept};
    close   = (state != HOLD) && (new_cnt != '0) && ((new_cnt == LAST) || flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      rdy       <= 1'b0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          acc <= new_acc;
          cnt <= new_cnt;
          sat <= new_sat;
          if (close) begin
            state     <= HOLD;
            rdy       <= 1'b0;
            out_valid <= 1'b1;
            out_total <= new_acc;
            out_count <= new_cnt;
            out_sat   <= new_sat;
          end else begin
            state <= (new_cnt == '0) ? IDLE : ACCUM;
            rdy   <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            rdy       <= 1'b1;
            out_valid <= 1'b0;
            out_total <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
          end else begin
            rdy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sum_accum.sv
// Bench for add_sum_accum: two instances (4 and 16 samples per block) checked every
// cycle against a block-level model, plus directed scenarios with literal results.
module tb_add_sum_accum;

  typedef struct {
    int unsigned tot;
    int unsigned cnt;
    bit          sat;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv   [2];
  logic [4:0] isum [2];
  logic       fl   [2];
  logic       ordy [2];
  logic       ir   [2];
  logic       ov   [2];
  logic [7:0] ot   [2];
  logic [7:0] oc   [2];
  logic       os   [2];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  add_sum_accum #(.SUM_W(5), .ACC_W(8), .NUM_SAMPLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_sum(isum[0]), .in_ready(ir[0]),
    .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_total(ot[0]),
    .out_count(oc[0]), .out_sat(os[0])
  );

  add_sum_accum #(.SUM_W(5), .ACC_W(8), .NUM_SAMPLES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_sum(isum[1]), .in_ready(ir[1]),
    .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_total(ot[1]),
    .out_count(oc[1]), .out_sat(os[1])
  );

  // ---------------- block-level reference model ----------------
  int unsigned m_sum   [2];
  int unsigned m_cnt   [2];
  bit          m_hold  [2];
  bit          m_live  [2];
  int unsigned r_total [2];
  int unsigned r_count [2];
  bit          r_sat   [2];
  res_t        rq0 [$];
  res_t        rq1 [$];

  function automatic int unsigned ns(input int d);
    return (d == 0) ? 4 : 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_sum[d] = 0; m_cnt[d] = 0; m_hold[d] = 0; m_live[d] = 0;
      end else if (!m_live[d]) begin
        m_live[d] = 1;
      end else if (m_hold[d]) begin
        if (ordy[d]) begin
          res_t r;
          r.tot = r_total[d]; r.cnt = r_count[d]; r.sat = r_sat[d];
          if (d == 0) rq0.push_back(r); else rq1.push_back(r);
          m_hold[d] = 0; m_sum[d] = 0; m_cnt[d] = 0;
        end
      end else begin
        if (iv[d]) begin
          m_sum[d] += isum[d];
          m_cnt[d] += 1;
        end
        if (m_cnt[d] > 0 && (m_cnt[d] == ns(d) || fl[d])) begin
          m_hold[d]  = 1;
          r_total[d] = (m_sum[d] > 255) ? 255 : m_sum[d];
          r_count[d] = m_cnt[d];
          r_sat[d]   = (m_sum[d] > 255);
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("rst_in_ready", d, ir[d], 0);
        chk("rst_out_valid", d, ov[d], 0);
        chk("rst_out_total", d, ot[d], 0);
        chk("rst_out_count", d, oc[d], 0);
        chk("rst_out_sat", d, os[d], 0);
      end else begin
        chk("in_ready", d, ir[d], (m_live[d] && !m_hold[d]) ? 1 : 0);
        chk("out_valid", d, ov[d], m_hold[d] ? 1 : 0);
        if (m_hold[d]) begin
          chk("out_total", d, ot[d], r_total[d]);
          chk("out_count", d, oc[d], r_count[d]);
          chk("out_sat", d, os[d], r_sat[d] ? 1 : 0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input int unsigned v);
    bit a;
    bit done = 0;
    iv[d]   = 1'b1;
    isum[d] = 5'(v);
    for (int k = 0; k < 50 && !done; k++) begin
      a = ir[d];
      cyc();
      done = a;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL send_timeout dut%0d: got no accept, expected accept within 50 cycles", d);
    end
  endtask

  task automatic chk_last(input string nm, input int d, input int unsigned tot,
                          input int unsigned cnt, input bit sat);
    res_t r;
    int unsigned sz;
    sz = (d == 0) ? rq0.size() : rq1.size();
    if (sz == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s dut%0d: got no result, expected total=%0d count=%0d", nm, d, tot, cnt);
    end else begin
      r = (d == 0) ? rq0[$] : rq1[$];
      chk({nm, "_total"}, d, r.tot, tot);
      chk({nm, "_count"}, d, r.cnt, cnt);
      chk({nm, "_sat"}, d, r.sat, sat);
    end
  endtask

  task automatic rand_run(input int d, input int n);
    bit a;
    bit pend = 0;
    for (int i = 0; i < n; i++) begin
      if (!pend) begin
        iv[d]   = ($urandom_range(3) != 0);
        isum[d] = 5'($urandom_range(31));
      end
      fl[d]   = ($urandom_range(7) == 0);
      ordy[d] = ($urandom_range(2) != 0);
      a = ir[d];
      cyc();
      pend = iv[d] && !a;
    end
    iv[d] = 1'b0; fl[d] = 1'b0; ordy[d] = 1'b1;
    cyc(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned sz;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; isum[d] = '0; fl[d] = 1'b0; ordy[d] = 1'b1;
    end
    cyc(3);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_release", 0, ir[0], 0);
    cyc();
    chk("ready_first_cycle", 0, ir[0], 1);
    chk("valid_first_cycle", 0, ov[0], 0);

    // 1: four sums, in_valid held
    send(0, 8); send(0, 7); send(0, 10); send(0, 11);
    iv[0] = 1'b0;
    chk("t1_valid_latency", 0, ov[0], 1);
    chk("t1_ready_low", 0, ir[0], 0);
    chk("t1_total_lit", 0, ot[0], 36);
    cyc();
    chk("t1_ready_back", 0, ir[0], 1);
    chk_last("t1", 0, 36, 4, 0);

    // 2: partial block closed by flush, then flush in IDLE
    send(0, 30); send(0, 30);
    iv[0] = 1'b0; fl[0] = 1'b1;
    cyc();
    fl[0] = 1'b0;
    cyc(2);
    chk_last("t2", 0, 60, 2, 0);
    sz = rq0.size();
    fl[0] = 1'b1;
    cyc();
    fl[0] = 1'b0;
    cyc(3);
    chk("t2_idle_flush", 0, rq0.size(), sz);

    // 5: flush on the same cycle as the third accept
    send(0, 1); send(0, 2);
    fl[0] = 1'b1;
    send(0, 3);
    fl[0] = 1'b0; iv[0] = 1'b0;
    cyc(2);
    chk_last("t5", 0, 6, 3, 0);

    // 4: backpressure in HOLD with a pending sum
    ordy[0] = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    isum[0] = 5'd9;
    for (int k = 0; k < 5; k++) begin
      chk("t4_ready_low", 0, ir[0], 0);
      chk("t4_total_held", 0, ot[0], 10);
      cyc();
    end
    ordy[0] = 1'b1;
    send(0, 9); send(0, 1); send(0, 1); send(0, 1);
    iv[0] = 1'b0;
    cyc(2);
    sz = rq0.size();
    if (sz >= 2) chk("t4_first_block", 0, rq0[sz-2].tot, 10);
    chk_last("t4", 0, 12, 4, 0);

    // 6: reset mid-block and in HOLD
    sz = rq0.size();
    send(0, 8); send(0, 9);
    iv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("t6_mid_ready", 0, ir[0], 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(2);
    ordy[0] = 1'b0;
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    iv[0] = 1'b0;
    chk("t6_hold_valid", 0, ov[0], 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_hold_valid_rst", 0, ov[0], 0);
    chk("t6_hold_total_rst", 0, ot[0], 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    ordy[0] = 1'b1;
    cyc(2);
    chk("t6_no_result", 0, rq0.size(), sz);
    send(0, 5); send(0, 6); send(0, 7); send(0, 8);
    iv[0] = 1'b0;
    cyc(2);
    chk_last("t6", 0, 26, 4, 0);

    rand_run(0, 400);

    // 3: saturation with 16 samples, next block starts clean
    for (int k = 0; k < 16; k++) send(1, 30);
    iv[1] = 1'b0;
    cyc(2);
    chk_last("t3", 1, 255, 16, 1);
    send(1, 1);
    fl[1] = 1'b1;
    send(1, 2);
    fl[1] = 1'b0; iv[1] = 1'b0;
    cyc(2);
    chk_last("t3_next", 1, 3, 2, 0);

    rand_run(1, 600);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
